vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (range 1..8).
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port en  input  1  timing enable; low holds the generator idle.
REQ-009 SHALL have port pix_en  output  1  one-clk pulse per pixel period.
REQ-010 SHALL have ports hcount, vcount  output  11 each  current pixel column and line.
REQ-011 SHALL have port blank  output  1  high outside the active region.
REQ-012 SHALL have ports hsync, vsync  output  1 each  active-low sync.
REQ-013 SHALL have ports line_start, frame_start  output  1 each  one-clk pulses.
REQ-014 SHALL have port frame_count  output  8  frames completed, modulo 256.

Function
REQ-015 SHALL assert pix_en for exactly one clk every CLK_DIV clks while en=1; with CLK_DIV=1, pix_en SHALL equal en.
REQ-016 SHALL change hcount, vcount, blank, hsync, vsync, line_start, frame_start only on clks where pix_en=1.
REQ-017 SHALL advance hcount by 1 per pix_en and wrap it from H_TOTAL-1 to 0, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800).
REQ-018 SHALL advance vcount by 1 on each hcount wrap and wrap it from V_TOTAL-1 to 0, where V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-019 SHALL register blank, hsync and vsync from the next counter values, so they always decode the hcount/vcount presented in the same cycle (zero relative latency).
REQ-020 SHALL drive blank=1 iff hcount>=H_ACTIVE or vcount>=V_ACTIVE.
REQ-021 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-022 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491), for all hcount on those lines.
REQ-023 SHALL pulse line_start for one clk in the cycle hcount becomes 0.
REQ-024 SHALL pulse frame_start for one clk in the cycle (hcount,vcount) becomes (0,0); line_start SHALL also pulse in that cycle.
REQ-025 SHALL increment frame_count in the same cycle frame_start pulses, wrapping 255->0.
REQ-026 SHALL, while en=0, hold hcount=0, vcount=0, blank=1, hsync=1, vsync=1, and suppress pix_en, line_start and frame_start; frame_count SHALL hold.
REQ-027 SHALL, on en 0->1, issue the first pix_en CLK_DIV clks later, moving to (0,0) with frame_start and line_start pulsing and blank=0.
REQ-028 SHALL, if en falls mid-frame, return to the idle state of REQ-026 on the next clk, abandoning the frame without incrementing frame_count.

Reset
REQ-029 SHALL, while rst=0, asynchronously force hcount=0, vcount=0, frame_count=0, blank=1, hsync=1, vsync=1, pix_en=0, line_start=0, frame_start=0 and the divider count to 0.
REQ-030 SHALL, after rst deasserts with en=1, behave exactly as on an en 0->1 edge (REQ-027).

Structure
REQ-031 SHALL take its default timing constants and the derived H_TOTAL/V_TOTAL from the team's shared VGA parameter include file, which other display blocks also use.
REQ-032 SHALL implement pixel-enable generation in one sub-module, pix_tick_gen (ports clk, rst, en, pix_en; parameter CLK_DIV).

Verification
REQ-033 SHALL verify defaults: 1000 frames -> 800 pix_en per line_start, 525 line_starts per frame_start, and frame_count wraps to 232 (1000 mod 256).
REQ-034 SHALL verify sync: hsync low exactly 96 pixels starting at hcount=656; vsync low exactly on vcount 490 and 491; blank rises at hcount 639->640 and at vcount 479->480.
REQ-035 SHALL verify rst pulsed at (hcount=300, vcount=200) -> all outputs hold reset values asynchronously; after release, (0,0) with frame_start appears CLK_DIV clks later.
REQ-036 SHALL verify en dropped at (700,100) for 10 clks -> idle values with no pix_en; re-enable -> frame_start CLK_DIV clks later; frame_count is unchanged.
REQ-037 SHALL verify CLK_DIV=1 -> pix_en continuously high and one frame_start per 420000 clks; with CLK_DIV=4 -> one frame_start per 1680000 clks.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared VGA timing constants used by the display blocks: default 640x480@60
// porch/sync widths, the derived line and frame totals, common counter
// widths, the generator state type and a small window-decode helper.
// ---------------------------------------------------------------------------
package vga_timing_gen_pkg;

    // Horizontal timing in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // System clocks per pixel
    localparam int VGA_CLK_DIV  = 2;

    localparam int CNT_W        = 11;
    localparam int FRAME_CNT_W  = 8;
    localparam int DIV_CNT_W    = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [0:0] {
        TG_IDLE = 1'b0,
        TG_RUN  = 1'b1
    } tg_state_e;

    // True when lo <= value < hi
    function automatic logic in_window(input cnt_t value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick_gen.sv
// ---------------------------------------------------------------------------
// pix_tick_gen
// Pixel-rate strobe generator. Divides clk by CLK_DIV while en is high.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   en     : enable; low clears the divider so the next strobe comes a full
//            CLK_DIV clocks after en returns
//   pix_en : strobe, high for one clk out of every CLK_DIV while en=1
// The strobe is a look-ahead: it is high in the clk whose rising edge should
// advance the pixel state. The parent registers it together with that state,
// so the externally visible pixel enable lines up with the counters.
// ---------------------------------------------------------------------------
module pix_tick_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_en
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);

    logic [DIV_CNT_W-1:0] div_cnt_r;
    logic                 at_last_s;

    // Terminal count of the divider
    always_comb begin
        at_last_s = (div_cnt_r == DIV_LAST);
    end

    // Divider counter: held at zero while disabled, wraps at CLK_DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= {DIV_CNT_W{1'b0}};
        end else if (!en) begin
            div_cnt_r <= {DIV_CNT_W{1'b0}};
        end else if (at_last_s) begin
            div_cnt_r <= {DIV_CNT_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_CNT_W'(1);
        end
    end

    assign pix_en = en & at_last_s;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   en           : timing enable; low holds the generator idle at (0,0)
//   pix_en       : one-clk pulse per pixel period
//   hcount       : current pixel column
//   vcount       : current line
//   blank        : high outside the active region
//   hsync, vsync : active-low sync
//   line_start   : one-clk pulse when hcount becomes 0
//   frame_start  : one-clk pulse when (hcount,vcount) becomes (0,0)
//   frame_count  : completed frames modulo 256
// All outputs are registered at the same edge, and blank/sync decode the next
// counter values so they always match the counters shown alongside them.
// A frame only counts as completed when the raster wraps from the last pixel
// back to (0,0); the first frame after enable or reset, and any frame cut
// short by en falling, leave frame_count untouched.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int CLK_DIV  = VGA_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        pix_en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);

    logic                   tick_s;
    tg_state_e              state_r;
    tg_state_e              state_nxt_s;
    cnt_t                   h_nxt_s;
    cnt_t                   v_nxt_s;
    logic                   frame_done_s;
    logic                   blank_nxt_s;
    logic                   hsync_nxt_s;
    logic                   vsync_nxt_s;

    logic                   pix_en_r;
    cnt_t                   hcount_r;
    cnt_t                   vcount_r;
    logic                   blank_r;
    logic                   hsync_r;
    logic                   vsync_r;
    logic                   line_start_r;
    logic                   frame_start_r;
    logic [FRAME_CNT_W-1:0] frame_count_r;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pix_en (tick_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= TG_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and next raster position; the first tick out of idle lands on (0,0)
    always_comb begin
        state_nxt_s  = state_r;
        h_nxt_s      = hcount_r;
        v_nxt_s      = vcount_r;
        frame_done_s = 1'b0;
        case (state_r)
            TG_IDLE: begin
                if (tick_s) begin
                    state_nxt_s = TG_RUN;
                    h_nxt_s     = 11'd0;
                    v_nxt_s     = 11'd0;
                end else begin
                    state_nxt_s = TG_IDLE;
                end
            end
            TG_RUN: begin
                if (!en) begin
                    state_nxt_s = TG_IDLE;
                    h_nxt_s     = 11'd0;
                    v_nxt_s     = 11'd0;
                end else if (tick_s) begin
                    if (hcount_r == H_LAST) begin
                        h_nxt_s = 11'd0;
                        if (vcount_r == V_LAST) begin
                            v_nxt_s      = 11'd0;
                            frame_done_s = 1'b1;
                        end else begin
                            v_nxt_s = vcount_r + 11'd1;
                        end
                    end else begin
                        h_nxt_s = hcount_r + 11'd1;
                    end
                end else begin
                    state_nxt_s = TG_RUN;
                end
            end
            default: begin
                state_nxt_s = TG_IDLE;
                h_nxt_s     = 11'd0;
                v_nxt_s     = 11'd0;
            end
        endcase
    end

    // Blank and sync decoded from the next position so they register with it
    always_comb begin
        blank_nxt_s = ~(in_window(h_nxt_s, 0, H_ACTIVE) && in_window(v_nxt_s, 0, V_ACTIVE));
        hsync_nxt_s = ~in_window(h_nxt_s, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
        vsync_nxt_s = ~in_window(v_nxt_s, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    end

    // Output registers: idle values while disabled, update only on pixel ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en_r      <= 1'b0;
            hcount_r      <= 11'd0;
            vcount_r      <= 11'd0;
            blank_r       <= 1'b1;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= 8'd0;
        end else if (!en) begin
            pix_en_r      <= 1'b0;
            hcount_r      <= 11'd0;
            vcount_r      <= 11'd0;
            blank_r       <= 1'b1;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (tick_s) begin
            pix_en_r      <= 1'b1;
            hcount_r      <= h_nxt_s;
            vcount_r      <= v_nxt_s;
            blank_r       <= blank_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            line_start_r  <= (h_nxt_s == 11'd0);
            frame_start_r <= (h_nxt_s == 11'd0) && (v_nxt_s == 11'd0);
            if (frame_done_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end else begin
            pix_en_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign pix_en      = pix_en_r;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign blank       = blank_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_count = frame_count_r;

endmodule
